// File: rtl/mmio_uart_tx_if.sv
// mmio_uart_tx_if: CPU peripheral bus bundle for mmio_uart_tx.
//   addr     [15:0] CPU address
//   in_data  [7:0]  write data from the CPU
//   out_data [7:0]  read data toward the shared data bus (0 when not driving)
//   out_en          high while out_data must drive the shared bus
//   ce, r, w, oe    cycle valid, read strobe, write strobe, output enable
// master = CPU side, slave = peripheral side.
interface mmio_uart_tx_if;
  logic [15:0] addr;
  logic [7:0]  in_data;
  logic [7:0]  out_data;
  logic        out_en;
  logic        ce;
  logic        r;
  logic        w;
  logic        oe;

  modport master (output addr, in_data, ce, r, w, oe, input out_data, out_en);
  modport slave  (input addr, in_data, ce, r, w, oe, output out_data, out_en);
endinterface

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped 8N1 UART transmitter with a small TX FIFO.
// Register window at BASE_ADDR (4 bytes):
//   0 TXDATA (W)  1 STATUS (R)  2 DIV_LO (R/W)  3 DIV_HI (R/W)
// STATUS = {count[3:0] (sat. 15), overflow, busy, empty, full}.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  CPU bus (slave modport)
//   tx   serial output, idle high, LSB first
//   irq  high while FIFO is empty and the shifter is idle
module mmio_uart_tx #(
  parameter logic [15:0] BASE_ADDR  = 16'hFF00,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [15:0] DIV_RESET  = 16'd103
) (
  input  logic                clk,
  input  logic                rst,
  mmio_uart_tx_if.slave       bus,
  output logic                tx,
  output logic                irq
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

  // Bus decode
  logic sel, wr_en, rd_en, push_req;
  assign sel      = bus.ce && (bus.addr[15:2] == BASE_ADDR[15:2]);
  assign wr_en    = sel && bus.w && !bus.r;
  assign rd_en    = sel && bus.r && !bus.w;
  assign push_req = wr_en && (bus.addr[1:0] == 2'd0);

  // State
  state_e        state_q;
  logic [7:0]    shift_q;
  logic [2:0]    bit_idx_q;
  logic [15:0]   baud_q;
  logic          tx_q;

  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [15:0]   div_q, div_d;
  logic          ovf_q, ovf_d;
  logic          rd_pend_q, rd_pend_d;
  logic          irq_q, irq_d;
  logic [7:0]    rdata_q, rdata_d;

  logic full, empty, busy, bit_done, pop, push;
  assign empty    = (count_q == '0);
  assign full     = (count_q == CW'(FIFO_DEPTH));
  assign busy     = (state_q != S_IDLE);
  assign bit_done = (baud_q == 16'd0);
  // The shifter takes the head either from idle or at the end of a stop bit.
  assign pop      = !empty && ((state_q == S_IDLE) || ((state_q == S_STOP) && bit_done));
  // A pop on the same edge frees a slot, so a write while full still lands.
  assign push     = push_req && (!full || pop);

  logic [4:0] count_ext;
  logic [3:0] count_sat;
  logic [7:0] status;
  assign count_ext = 5'(count_q);
  assign count_sat = (count_ext > 5'd15) ? 4'hF : count_ext[3:0];
  assign status    = {count_sat, ovf_q, busy, empty, full};

  always_comb begin
    // NOTE: every _d gets its default first so no latch is inferred.
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q + CW'(push) - CW'(pop);
    div_d     = div_q;
    ovf_d     = ovf_q;
    rd_pend_d = rd_en;
    rdata_d   = 8'h00;
    irq_d     = empty && !busy;

    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;

    if (wr_en) begin
      case (bus.addr[1:0])
        2'd2:    div_d[7:0]  = bus.in_data;
        2'd3:    div_d[15:8] = bus.in_data;
        default: ;
      endcase
    end

    if (rd_en) begin
      case (bus.addr[1:0])
        2'd1:    rdata_d = status;
        2'd2:    rdata_d = div_q[7:0];
        2'd3:    rdata_d = div_q[15:8];
        default: rdata_d = 8'h00;
      endcase
    end

    // Clear-on-read of STATUS; a dropped byte on the same edge wins.
    if (rd_en && (bus.addr[1:0] == 2'd1)) ovf_d = 1'b0;
    if (push_req && !push)                ovf_d = 1'b1;
  end

  // NOTE: clocked blocks use non-blocking assignments only, so every flop
  // samples the pre-edge value regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      div_q     <= DIV_RESET;
      ovf_q     <= 1'b0;
      rd_pend_q <= 1'b0;
      rdata_q   <= 8'h00;
      irq_q     <= 1'b1;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      div_q     <= div_d;
      ovf_q     <= ovf_d;
      rd_pend_q <= rd_pend_d;
      rdata_q   <= rdata_d;
      irq_q     <= irq_d;
    end
  end

  // NOTE: FIFO storage is not reset; pointers and count define which
  // entries are valid, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= bus.in_data;
  end

  // Shifter FSM. The divisor is sampled only at bit starts, so a divisor
  // write never truncates the bit in flight. Data shifts right, LSB first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      shift_q   <= 8'h00;
      bit_idx_q <= 3'd0;
      baud_q    <= 16'd0;
      tx_q      <= 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          tx_q <= 1'b1;
          if (pop) begin
            shift_q <= fifo_mem[rd_ptr_q];
            baud_q  <= div_q;
            state_q <= S_START;
            tx_q    <= 1'b0;
          end
        end
        S_START: begin
          if (bit_done) begin
            state_q   <= S_DATA;
            bit_idx_q <= 3'd0;
            baud_q    <= div_q;
            tx_q      <= shift_q[0];
          end else begin
            baud_q <= baud_q - 16'd1;
          end
        end
        S_DATA: begin
          if (bit_done) begin
            baud_q <= div_q;
            if (bit_idx_q == 3'd7) begin
              state_q <= S_STOP;
              tx_q    <= 1'b1;
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
              shift_q   <= shift_q >> 1;
              tx_q      <= shift_q[1];
            end
          end else begin
            baud_q <= baud_q - 16'd1;
          end
        end
        S_STOP: begin
          if (bit_done) begin
            if (pop) begin
              shift_q <= fifo_mem[rd_ptr_q];
              baud_q  <= div_q;
              state_q <= S_START;
              tx_q    <= 1'b0;
            end else begin
              state_q <= S_IDLE;
              tx_q    <= 1'b1;
            end
          end else begin
            baud_q <= baud_q - 16'd1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          tx_q    <= 1'b1;
        end
      endcase
    end
  end

  assign bus.out_en   = rd_pend_q && bus.oe;
  assign bus.out_data = bus.out_en ? rdata_q : 8'h00;
  assign tx           = tx_q;
  assign irq          = irq_q;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb_mmio_uart_tx: self-checking bench for mmio_uart_tx.
// Register accesses come from a vector table; serial frames are decoded by a
// monitor and compared against a scoreboard queue filled when bytes are written.
module tb_mmio_uart_tx;

  logic clk = 1'b0;
  logic rst;
  logic tx, irq;

  mmio_uart_tx_if bus();

  mmio_uart_tx #(
    .BASE_ADDR (16'hFF00),
    .FIFO_DEPTH(4),
    .DIV_RESET (16'd103)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .tx (tx),
    .irq(irq)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard and monitor state
  logic [7:0] exp_q[$];
  int         starts[$];
  int         cur_div = 103;
  int         frames = 0;
  int         mon_last_end = 0;
  logic       mon_busy = 1'b0;

  initial begin : monitor
    int p, k;
    logic [7:0] rx, exp_b;
    logic fmt_ok, aborted, bitv;
    forever begin
      @(negedge clk);
      if (!rst && tx === 1'b0) begin
        p = cur_div + 1;
        mon_busy = 1'b1;
        starts.push_back(cyc);
        aborted = 1'b0;
        fmt_ok = 1'b1;
        rx = 8'h00;
        bitv = 1'b0;
        for (int i = 0; i < 10 * p; i++) begin
          if (i > 0) begin
            @(negedge clk);
            if (rst) begin
              aborted = 1'b1;
              break;
            end
          end
          k = i / p;
          if (i % p == 0) bitv = tx;
          else if (tx !== bitv) fmt_ok = 1'b0;
          if (k >= 1 && k <= 8) rx[k-1] = bitv;
          if (k == 0 && tx !== 1'b0) fmt_ok = 1'b0;
          if (k == 9 && tx !== 1'b1) fmt_ok = 1'b0;
        end
        mon_last_end = cyc;
        if (!aborted) begin
          frames++;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_frame: got %0h expected no frame", rx);
          end else begin
            exp_b = exp_q.pop_front();
            check("frame_data", rx, exp_b);
            check("frame_format", fmt_ok, 1'b1);
          end
        end
        mon_busy = 1'b0;
      end
    end
  end

  // Bus helpers: inputs change on the falling edge, outputs sampled there too.
  task automatic bus_drive(input logic wr, input logic rd, input logic [15:0] a,
                           input logic [7:0] d, input logic oe_v);
    @(negedge clk);
    bus.ce = 1'b1;
    bus.w = wr;
    bus.r = rd;
    bus.addr = a;
    bus.in_data = d;
    bus.oe = oe_v;
  endtask

  task automatic bus_release();
    @(negedge clk);
    bus.ce = 1'b0;
    bus.w = 1'b0;
    bus.r = 1'b0;
  endtask

  task automatic reg_write(input logic [15:0] a, input logic [7:0] d);
    bus_drive(1'b1, 1'b0, a, d, 1'b1);
    bus_release();
  endtask

  task automatic read_check(input string name, input logic [15:0] a, input logic [7:0] exp);
    bus_drive(1'b0, 1'b1, a, 8'h00, 1'b1);
    @(negedge clk);
    check({name, "_data"}, bus.out_data, exp);
    check({name, "_en"}, bus.out_en, 1'b1);
    bus.ce = 1'b0;
    bus.r = 1'b0;
    @(negedge clk);
    check({name, "_en_after"}, bus.out_en, 1'b0);
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || mon_busy || irq !== 1'b1) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, (n < budget), 1'b1);
  endtask

  typedef struct {
    logic        w;
    logic        r;
    logic        oe;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  exp_data;
    logic        exp_en;
    logic        chk;
  } vec_t;

  vec_t vecs[21];

  initial begin
    int n, t_irq;
    logic [7:0] d;
    logic en, en2;

    vecs[0]  = '{1'b0, 1'b1, 1'b1, 16'hFF01, 8'h00, 8'h02, 1'b1, 1'b1};
    vecs[1]  = '{1'b0, 1'b1, 1'b1, 16'hFF02, 8'h00, 8'h67, 1'b1, 1'b1};
    vecs[2]  = '{1'b0, 1'b1, 1'b1, 16'hFF03, 8'h00, 8'h00, 1'b1, 1'b1};
    vecs[3]  = '{1'b0, 1'b1, 1'b1, 16'hFF00, 8'h00, 8'h00, 1'b1, 1'b1};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 16'hFF01, 8'h00, 8'h00, 1'b0, 1'b1};
    vecs[5]  = '{1'b1, 1'b0, 1'b1, 16'hFF02, 8'h3C, 8'h00, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 1'b1, 16'hFF03, 8'h12, 8'h00, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 1'b1, 16'hFF02, 8'h00, 8'h3C, 1'b1, 1'b1};
    vecs[8]  = '{1'b0, 1'b1, 1'b1, 16'hFF03, 8'h00, 8'h12, 1'b1, 1'b1};
    vecs[9]  = '{1'b0, 1'b1, 1'b1, 16'hFF04, 8'h00, 8'h00, 1'b0, 1'b1};
    vecs[10] = '{1'b0, 1'b1, 1'b1, 16'hFEFF, 8'h00, 8'h00, 1'b0, 1'b1};
    vecs[11] = '{1'b1, 1'b1, 1'b1, 16'hFF02, 8'h55, 8'h00, 1'b0, 1'b1};
    vecs[12] = '{1'b1, 1'b0, 1'b1, 16'hFF06, 8'h99, 8'h00, 1'b0, 1'b0};
    vecs[13] = '{1'b0, 1'b1, 1'b1, 16'hFF02, 8'h00, 8'h3C, 1'b1, 1'b1};
    vecs[14] = '{1'b1, 1'b0, 1'b1, 16'hFF04, 8'hAA, 8'h00, 1'b0, 1'b0};
    vecs[15] = '{1'b1, 1'b1, 1'b1, 16'hFF00, 8'h77, 8'h00, 1'b0, 1'b1};
    vecs[16] = '{1'b0, 1'b1, 1'b1, 16'hFF01, 8'h00, 8'h02, 1'b1, 1'b1};
    vecs[17] = '{1'b1, 1'b0, 1'b1, 16'hFF03, 8'h00, 8'h00, 1'b0, 1'b0};
    vecs[18] = '{1'b1, 1'b0, 1'b1, 16'hFF02, 8'h03, 8'h00, 1'b0, 1'b0};
    vecs[19] = '{1'b0, 1'b1, 1'b1, 16'hFF02, 8'h00, 8'h03, 1'b1, 1'b1};
    vecs[20] = '{1'b0, 1'b1, 1'b1, 16'hFF03, 8'h00, 8'h00, 1'b1, 1'b1};

    // Reset state
    rst = 1'b1;
    bus.ce = 1'b0; bus.r = 1'b0; bus.w = 1'b0; bus.oe = 1'b1;
    bus.addr = 16'h0000; bus.in_data = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_tx", tx, 1'b1);
    check("rst_irq", irq, 1'b1);
    check("rst_out_en", bus.out_en, 1'b0);
    check("rst_out_data", bus.out_data, 8'h00);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Register map, out-of-window and r&w-together cycles
    foreach (vecs[i]) begin
      bus_drive(vecs[i].w, vecs[i].r, vecs[i].addr, vecs[i].wdata, vecs[i].oe);
      @(negedge clk);
      d = bus.out_data;
      en = bus.out_en;
      bus.ce = 1'b0; bus.r = 1'b0; bus.w = 1'b0;
      @(negedge clk);
      en2 = bus.out_en;
      bus.oe = 1'b1;
      if (vecs[i].chk) begin
        check($sformatf("vec%0d_data", i), d, vecs[i].exp_data);
        check($sformatf("vec%0d_en", i), en, vecs[i].exp_en);
        check($sformatf("vec%0d_en_after", i), en2, 1'b0);
      end
    end
    cur_div = 3;
    check("tx_idle_after_table", tx, 1'b1);
    check("irq_idle_after_table", irq, 1'b1);

    // Single frame at DIV=3, irq timing
    bus_drive(1'b1, 1'b0, 16'hFF00, 8'hA5, 1'b1);
    exp_q.push_back(8'hA5);
    bus_release();
    @(negedge clk);
    check("irq_fall", irq, 1'b0);
    n = 0;
    while (irq !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    t_irq = cyc;
    check("irq_rise_timeout", (n < 200), 1'b1);
    check("irq_rise_after_stop", (t_irq - mon_last_end >= 1) && (t_irq - mon_last_end <= 2), 1'b1);
    wait_drain("drain_a5", 200);

    // Back-to-back frames at DIV=0
    reg_write(16'hFF02, 8'h00);
    cur_div = 0;
    bus_drive(1'b1, 1'b0, 16'hFF00, 8'h01, 1'b1); exp_q.push_back(8'h01);
    bus_drive(1'b1, 1'b0, 16'hFF00, 8'h02, 1'b1); exp_q.push_back(8'h02);
    bus_drive(1'b1, 1'b0, 16'hFF00, 8'h03, 1'b1); exp_q.push_back(8'h03);
    read_check("status_count2", 16'hFF01, 8'h24);
    wait_drain("drain_b2b", 200);
    n = starts.size();
    check("b2b_gap_1", starts[n-2] - starts[n-3], 10);
    check("b2b_gap_2", starts[n-1] - starts[n-2], 10);

    // Overflow at DIV=100
    reg_write(16'hFF02, 8'd100);
    cur_div = 100;
    for (int i = 0; i < 6; i++) begin
      bus_drive(1'b1, 1'b0, 16'hFF00, 8'h30 + 8'(i), 1'b1);
      if (i < 5) exp_q.push_back(8'h30 + 8'(i));
    end
    read_check("status_ovf", 16'hFF01, 8'h4D);
    read_check("status_ovf_cleared", 16'hFF01, 8'h45);
    wait_drain("drain_ovf", 6000);
    read_check("status_after_ovf", 16'hFF01, 8'h02);

    // Reset during data bit 3 with two bytes queued
    reg_write(16'hFF02, 8'h03);
    cur_div = 3;
    bus_drive(1'b1, 1'b0, 16'hFF00, 8'hC3, 1'b1); exp_q.push_back(8'hC3);
    bus_drive(1'b1, 1'b0, 16'hFF00, 8'h5A, 1'b1); exp_q.push_back(8'h5A);
    bus_drive(1'b1, 1'b0, 16'hFF00, 8'hF0, 1'b1); exp_q.push_back(8'hF0);
    bus_release();
    n = 0;
    while (!mon_busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("rst_test_frame_started", mon_busy, 1'b1);
    repeat (17) @(negedge clk);
    check("rst_test_tx_low_bit3", tx, 1'b0);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_tx", tx, 1'b1);
    check("rst_mid_irq", irq, 1'b1);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    cur_div = 103;
    n = frames;
    read_check("status_after_rst", 16'hFF01, 8'h02);
    read_check("div_lo_after_rst", 16'hFF02, 8'h67);
    repeat (300) @(negedge clk);
    check("no_frames_after_rst", frames, n);
    check("tx_high_after_rst", tx, 1'b1);
    check("irq_after_rst", irq, 1'b1);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mmio_uart_tx.md
Name: mmio_uart_tx

Overview:
- Memory-mapped UART transmitter that answers CPU bus cycles (addr/data, ce/r/w/oe strobes) as a peripheral, alongside main memory.
- Bytes the CPU writes are queued in a small TX FIFO and serialized 8N1, LSB first, on a single output pin.
- Status and baud registers are readable over the same bus, so software can poll before writing.

Parameters:
- BASE_ADDR, 16'hFF00, first byte address of the 4-byte register window (must be 4-aligned).
- FIFO_DEPTH, 4, TX FIFO entries (power of two, 2..16).
- DIV_RESET, 16'd103, reset value of the baud divisor; bit period = DIV+1 clk cycles.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- addr  in  16  CPU address bus.
- in_data  in  8  CPU data bus, write data.
- out_data  out  8  read data toward data bus.
- out_en  out  1  high while out_data must drive the shared data bus.
- ce  in  1  bus cycle valid.
- r  in  1  read strobe.
- w  in  1  write strobe.
- oe  in  1  output enable from CPU.
- tx  out  1  serial output, idle high.
- irq  out  1  high while FIFO is empty and the shifter is idle (transmit done).

Behaviour:
- Register map:
  - sel = ce && addr[15:2] == BASE_ADDR[15:2]; reg index = addr[1:0].
  - 0 TXDATA: write-only; reads return 8'h00.
  - 1 STATUS: read-only.
    - bit0 full, bit1 empty, bit2 busy (shifter active), bit3 overflow (sticky).
    - bits7:4 = FIFO count, saturating at 15.
  - 2 DIV_LO: read/write, divisor[7:0].
  - 3 DIV_HI: read/write, divisor[15:8].
- Write cycle:
  - Register update at the rising edge where sel && w && !r.
  - sel && w && r together is ignored.
  - A write to TXDATA while full drops the byte and sets overflow.
- Read cycle:
  - On the edge where sel && r && !w, the addressed register is latched into out_data. Latency is 1 cycle.
  - out_en = registered(sel && r && !w) && oe, held only for that following cycle.
  - When out_en is low, out_data is 8'h00.
  - Reading STATUS clears overflow on the same edge it is sampled (the sampled value still shows 1).
- FIFO:
  - Circular buffer; read/write pointers wrap modulo FIFO_DEPTH.
  - Count ranges 0..FIFO_DEPTH.
  - A push and a pop on the same edge both occur and count is unchanged; allowed even when full, because the pop frees a slot first.
- Baud counter:
  - 16-bit down-counter, reloaded with divisor at each bit start; a bit ends when the counter reaches 0.
  - Divisor writes take effect at the next bit start; they never truncate the current bit.
  - Divisor 0 gives 1 clk per bit.
- Shifter FSM:
  - IDLE:
    - tx=1.
    - If FIFO is not empty: pop the head into shift_reg, load the baud counter, go to START.
  - START: tx=0 for one bit period, then DATA with bit_idx=0.
  - DATA:
    - tx=shift_reg[bit_idx] for one bit period.
    - After bit_idx==7, go to STOP; otherwise bit_idx+1.
  - STOP:
    - tx=1 for one bit period.
    - Then, if FIFO is not empty, pop and go directly to START (back-to-back frames, no idle gap).
    - Else go to IDLE.
  - busy = state != IDLE.
  - Frame length is exactly 10*(DIV+1) clks.
- Reset values (async, immediate on rst rise):
  - tx=1, out_data=0, out_en=0.
  - FIFO empty, pointers 0, overflow=0.
  - divisor=DIV_RESET, state=IDLE, irq=1.
  - Reset mid-frame aborts the frame; tx returns high immediately and queued bytes are discarded.
- irq = (count==0) && (state==IDLE), registered.
- No response when addr is outside the window: out_en stays 0 and no state changes.

Test Plan:
- Reset, then read STATUS:
  - Expected: out_data=8'h02 one cycle after the strobe, out_en=1 that cycle only (with oe=1), tx=1, irq=1.
- Set DIV_LO=3, DIV_HI=0, then write TXDATA=8'hA5:
  - Expected on tx: start low 4 clks, then bits 1,0,1,0,0,1,0,1 at 4 clks each, then stop high 4 clks. Total 40 clks.
  - irq falls within 2 cycles of the write and rises after the stop bit.
- With DIV=0, write 8'h01, 8'h02, 8'h03 on consecutive cycles:
  - Expected: three back-to-back 10-clk frames with no idle gap.
  - STATUS count reads 2 right after the third write, while the first byte is shifting.
- With DIV=100, write 6 bytes at FIFO_DEPTH=4:
  - Expected: the first byte is popped into the shifter, four are queued, the sixth is dropped.
  - STATUS reads 8'h4D (count 4, overflow, busy, full); a second STATUS read shows overflow=0.
- Assert rst during bit 3 of a frame with 2 bytes queued:
  - Expected: tx=1 the same cycle, STATUS=8'h02 after release, and no further frames.
- Bus cycle to address BASE_ADDR+4, and a cycle with r and w both high:
  - Expected: out_en stays 0 and the FIFO and divisor are unchanged.
